// File: rtl/adder_sched_pkg.sv
// Shared types and sizing helpers for the multi-precision add scheduler.
package adder_sched_pkg;

    localparam int unsigned W_DEF      = 3;
    localparam int unsigned CHUNKS_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Chunk index width; never zero, so a single-chunk build still has a counter.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ripple_adder_w.sv
// W-bit ripple-carry adder; the single shared arithmetic resource of the scheduler.
module ripple_adder_w #(
    parameter int unsigned W = 3
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    logic [W:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign s[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[W];

endmodule

// File: rtl/ripple_add_sched.sv
// Two-requester multi-precision adder: round-robin arbitration, one W-bit chunk
// per cycle through a shared ripple adder, result returned over valid/ready.
module ripple_add_sched
    import adder_sched_pkg::*;
#(
    parameter int unsigned W      = W_DEF,
    parameter int unsigned CHUNKS = CHUNKS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    input  logic [W*CHUNKS-1:0] req0_a,
    input  logic [W*CHUNKS-1:0] req0_b,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [W*CHUNKS-1:0] req1_a,
    input  logic [W*CHUNKS-1:0] req1_b,
    output logic                req1_ready,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [W*CHUNKS-1:0] res_sum,
    output logic                res_cout,
    output logic                res_id
);

    localparam int unsigned   N      = W * CHUNKS;
    localparam int unsigned   KW     = idx_width(CHUNKS);
    localparam logic [KW-1:0] K_LAST = KW'(CHUNKS - 1);

    state_e        state_q, state_d;
    logic          rr_q, rr_d;
    logic [KW-1:0] k_q, k_d;
    logic          c_q, c_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          id_q, id_d;
    logic          valid_q;

    logic          any_valid_c;
    logic          grant_c;
    logic [31:0]   base_c;
    logic [W-1:0]  add_a_c;
    logic [W-1:0]  add_b_c;
    logic [W-1:0]  add_s_c;
    logic          add_cout_c;

    // rr only decides under contention; a lone requester always wins.
    always_comb begin
        any_valid_c = req0_valid | req1_valid;
        grant_c     = (req0_valid && req1_valid) ? rr_q : req1_valid;
    end

    assign req0_ready = !rst && (state_q == IDLE) && req0_valid && !grant_c;
    assign req1_ready = !rst && (state_q == IDLE) && req1_valid &&  grant_c;

    always_comb begin
        base_c  = 32'(k_q) * W;
        add_a_c = a_q[base_c +: W];
        add_b_c = b_q[base_c +: W];
    end

    ripple_adder_w #(
        .W (W)
    ) u_adder (
        .a    (add_a_c),
        .b    (add_b_c),
        .cin  (c_q),
        .s    (add_s_c),
        .cout (add_cout_c)
    );

    // Next-state: accept in IDLE, one chunk per RUN cycle, hold result in DONE.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        k_d     = k_q;
        c_d     = c_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        id_d    = id_q;

        case (state_q)
            IDLE: begin
                if (any_valid_c) begin
                    a_d     = grant_c ? req1_a : req0_a;
                    b_d     = grant_c ? req1_b : req0_b;
                    id_d    = grant_c;
                    k_d     = '0;
                    c_d     = 1'b0;
                    rr_d    = ~grant_c;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[base_c +: W] = add_s_c;
                c_d                = add_cout_c;
                k_d                = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    cout_d  = add_cout_c;
                    k_d     = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            k_q     <= '0;
            c_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            id_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            k_q     <= k_d;
            c_q     <= c_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            id_q    <= id_d;
            valid_q <= (state_d == DONE);
        end
    end

    assign res_valid = valid_q;
    assign res_sum   = sum_q;
    assign res_cout  = cout_q;
    assign res_id    = id_q;

endmodule
